// File: rtl/l1_dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped L1 data cache.
package l1_dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } state_e;

  // Wide enough for any address width this cache will ever be built with.
  localparam int MAX_ADDR_W = 64;
  typedef logic [MAX_ADDR_W-1:0] wide_addr_t;

  function automatic int calc_offset_w(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int calc_index_w(input int cache_size, input int block_size);
    return $clog2(cache_size / block_size);
  endfunction

  function automatic int calc_tag_w(input int addr_width, input int cache_size,
                                    input int block_size);
    return addr_width - calc_index_w(cache_size, block_size) - calc_offset_w(block_size);
  endfunction

  function automatic wide_addr_t addr_offset(input wide_addr_t addr, input int offset_w);
    return addr & ((wide_addr_t'(1) << offset_w) - wide_addr_t'(1));
  endfunction

  function automatic wide_addr_t addr_index(input wide_addr_t addr, input int offset_w,
                                            input int index_w);
    return (addr >> offset_w) & ((wide_addr_t'(1) << index_w) - wide_addr_t'(1));
  endfunction

  function automatic wide_addr_t addr_tag(input wide_addr_t addr, input int offset_w,
                                          input int index_w);
    return addr >> (offset_w + index_w);
  endfunction

endpackage

// File: rtl/l1_dcache_line_store.sv
// Tag/valid/dirty/data storage for the L1 data cache.
// One combinational read port, one registered write port that either fills a
// whole line or writes a single word (marking the line dirty).
module l1_line_store #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 16,
  parameter int BLOCK_SIZE = 16,
  parameter int TAG_W      = 24,
  parameter int INDEX_W    = 4,
  parameter int OFFSET_W   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [INDEX_W-1:0]                   rd_index,
  output logic [TAG_W-1:0]                     rd_tag,
  output logic                                 rd_valid,
  output logic                                 rd_dirty,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rd_block,
  input  logic                                 fill_en,
  input  logic                                 word_en,
  input  logic [INDEX_W-1:0]                   wr_index,
  input  logic [OFFSET_W-1:0]                  wr_offset,
  input  logic [TAG_W-1:0]                     fill_tag,
  input  logic                                 fill_dirty,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] fill_block,
  input  logic [DATA_WIDTH-1:0]                word_data
);

  logic [TAG_W-1:0]                     tag_mem  [NUM_LINES];
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] data_mem [NUM_LINES];
  logic [NUM_LINES-1:0]                 valid_q, valid_d;
  logic [NUM_LINES-1:0]                 dirty_q, dirty_d;

  assign rd_tag   = tag_mem[rd_index];
  assign rd_block = data_mem[rd_index];
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];

  // Next-state of the per-line status bits: a fill validates the line, a word write dirties it.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) begin
      valid_d[wr_index] = 1'b1;
      dirty_d[wr_index] = fill_dirty;
    end else if (word_en) begin
      dirty_d[wr_index] = 1'b1;
    end
  end

  // Status bits are the only storage that reset clears; dirty data is simply forgotten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays are plain RAM with no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[wr_index]  <= fill_tag;
      data_mem[wr_index] <= fill_block;
    end else if (word_en) begin
      data_mem[wr_index][wr_offset] <= word_data;
    end
  end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache in front of L2.
// Optional hit/miss counters are built when L1_DCACHE_STATS_EN is defined.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CACHE_SIZE = 256,
  parameter int BLOCK_SIZE = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [ADDR_WIDTH-1:0]                cpu_addr,
  input  logic [DATA_WIDTH-1:0]                cpu_wdata,
  input  logic                                 cpu_read,
  input  logic                                 cpu_write,
  output logic [DATA_WIDTH-1:0]                cpu_rdata,
  output logic                                 cpu_ready,
  output logic                                 cpu_hit,
  output logic [ADDR_WIDTH-1:0]                l2_addr,
  output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_wdata,
  input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_rdata,
  output logic                                 l2_read,
  output logic                                 l2_write,
  input  logic                                 l2_ready
`ifdef L1_DCACHE_STATS_EN
  ,
  output logic [31:0]                          stat_hits,
  output logic [31:0]                          stat_misses
`endif
);

  localparam int NUM_LINES = CACHE_SIZE / BLOCK_SIZE;
  localparam int OFFSET_W  = calc_offset_w(BLOCK_SIZE);
  localparam int INDEX_W   = calc_index_w(CACHE_SIZE, BLOCK_SIZE);
  localparam int TAG_W     = calc_tag_w(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE);

  state_e                               state_q, state_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
  logic                                 is_write_q, is_write_d;
  logic [DATA_WIDTH-1:0]                cpu_rdata_q, cpu_rdata_d;
  logic                                 cpu_ready_q, cpu_ready_d;
  logic                                 cpu_hit_q, cpu_hit_d;
  logic [ADDR_WIDTH-1:0]                l2_addr_q, l2_addr_d;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] l2_wdata_q, l2_wdata_d;

  logic [OFFSET_W-1:0]                  cur_offset;
  logic [INDEX_W-1:0]                   cur_index;
  logic [TAG_W-1:0]                     cur_tag;
  logic [ADDR_WIDTH-1:0]                refill_addr;

  logic [TAG_W-1:0]                     rd_tag;
  logic                                 rd_valid;
  logic                                 rd_dirty;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] rd_block;
  logic                                 hit;

  logic                                 fill_en;
  logic                                 word_en;
  logic                                 fill_dirty;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] fill_block;

  assign cur_offset  = OFFSET_W'(addr_offset(wide_addr_t'(addr_q), OFFSET_W));
  assign cur_index   = INDEX_W'(addr_index(wide_addr_t'(addr_q), OFFSET_W, INDEX_W));
  assign cur_tag     = TAG_W'(addr_tag(wide_addr_t'(addr_q), OFFSET_W, INDEX_W));
  assign refill_addr = {cur_tag, cur_index, {OFFSET_W{1'b0}}};
  assign hit         = rd_valid && (rd_tag == cur_tag);

  l1_line_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_LINES  (NUM_LINES),
    .BLOCK_SIZE (BLOCK_SIZE),
    .TAG_W      (TAG_W),
    .INDEX_W    (INDEX_W),
    .OFFSET_W   (OFFSET_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_index   (cur_index),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_block   (rd_block),
    .fill_en    (fill_en),
    .word_en    (word_en),
    .wr_index   (cur_index),
    .wr_offset  (cur_offset),
    .fill_tag   (cur_tag),
    .fill_dirty (fill_dirty),
    .fill_block (fill_block),
    .word_data  (wdata_q)
  );

  // Controller: next state, latched request, CPU response and L2 request fields.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = 1'b0;
    l2_addr_d   = l2_addr_q;
    l2_wdata_d  = l2_wdata_q;
    fill_en     = 1'b0;
    word_en     = 1'b0;
    fill_dirty  = 1'b0;
    fill_block  = l2_rdata;

    case (state_q)
      IDLE: begin
        // The CPU still holds its request during the ready cycle, so ignore it then.
        if (!cpu_ready_q && (cpu_read || cpu_write)) begin
          addr_d     = cpu_addr;
          wdata_d    = cpu_wdata;
          is_write_d = cpu_write;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          if (is_write_q) begin
            word_en = 1'b1;
          end else begin
            cpu_rdata_d = rd_block[cur_offset];
          end
          cpu_ready_d = 1'b1;
          cpu_hit_d   = 1'b1;
          state_d     = IDLE;
        end else if (rd_valid && rd_dirty) begin
          l2_addr_d  = {rd_tag, cur_index, {OFFSET_W{1'b0}}};
          l2_wdata_d = rd_block;
          state_d    = WRITEBACK;
        end else begin
          l2_addr_d = refill_addr;
          state_d   = REFILL;
        end
      end
      WRITEBACK: begin
        if (l2_ready) begin
          l2_addr_d = refill_addr;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        if (l2_ready) begin
          fill_en    = 1'b1;
          fill_dirty = is_write_q;
          if (is_write_q) begin
            fill_block[cur_offset] = wdata_q;
          end else begin
            cpu_rdata_d = l2_rdata[cur_offset];
          end
          cpu_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; reset abandons any L2 transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      l2_addr_q   <= '0;
      l2_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      l2_addr_q   <= l2_addr_d;
      l2_wdata_q  <= l2_wdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_hit   = cpu_hit_q;
  assign l2_addr   = l2_addr_q;
  assign l2_wdata  = l2_wdata_q;
  assign l2_read   = (state_q == REFILL) && !l2_ready;
  assign l2_write  = (state_q == WRITEBACK) && !l2_ready;

`ifdef L1_DCACHE_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;

  // Count each completed access once, split by whether it hit.
  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    if (cpu_ready_q) begin
      if (cpu_hit_q) begin
        stat_hits_d = stat_hits_q + 32'd1;
      end else begin
        stat_misses_d = stat_misses_q + 32'd1;
      end
    end
  end

  // Wrapping statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Directed testbench for l1_dcache with a behavioural L2 responder.
module tb_l1_dcache;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [AW-1:0]        cpu_addr;
  logic [DW-1:0]        cpu_wdata;
  logic                 cpu_read;
  logic                 cpu_write;
  logic [DW-1:0]        cpu_rdata;
  logic                 cpu_ready;
  logic                 cpu_hit;
  logic [AW-1:0]        l2_addr;
  logic [BS-1:0][DW-1:0] l2_wdata;
  logic [BS-1:0][DW-1:0] l2_rdata;
  logic                 l2_read;
  logic                 l2_write;
  logic                 l2_ready;

  always #5 clk = ~clk;

  l1_dcache #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CACHE_SIZE (256),
    .BLOCK_SIZE (BS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_hit   (cpu_hit),
    .l2_addr   (l2_addr),
    .l2_wdata  (l2_wdata),
    .l2_rdata  (l2_rdata),
    .l2_read   (l2_read),
    .l2_write  (l2_write),
    .l2_ready  (l2_ready)
  );

  typedef struct {
    bit          check_rdata;
    logic [31:0] rdata;
    logic        hit;
  } cpu_exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] w3;
  } l2_exp_t;

  cpu_exp_t    cpu_sb[$];
  l2_exp_t     l2_sb[$];
  logic [31:0] l2_mem [logic [31:0]];
  int          tests = 0;
  int          fails = 0;
  int          l2_lat = 3;

  // Default L2 contents: word 0x120+k holds 0xA000+k; written-back words override.
  function automatic logic [31:0] l2_word(input logic [31:0] a);
    if (l2_mem.exists(a)) return l2_mem[a];
    return 32'hA000 + (a - 32'h120);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushL2(input bit wr, input logic [31:0] addr, input logic [31:0] w3);
    l2_exp_t e;
    e.wr = wr;
    e.addr = addr;
    e.w3 = w3;
    l2_sb.push_back(e);
  endtask

  // Drives one CPU access, waits for the ready pulse and scores it.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit chk_rdata,
                               input logic [31:0] exp_rdata, input logic exp_hit,
                               input int exp_lat);
    cpu_exp_t e;
    int       cycles;
    bit       got;
    e.check_rdata = chk_rdata;
    e.rdata = exp_rdata;
    e.hit = exp_hit;
    cpu_sb.push_back(e);
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_read  = rd;
    cpu_write = wr;
    cycles = 0;
    got = 0;
    while (!got && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (cpu_ready === 1'b1) got = 1;
    end
    e = cpu_sb.pop_front();
    checkOutput($sformatf("cpu_ready for %h", addr), cpu_ready, 1'b1);
    if (got) begin
      if (e.check_rdata) checkOutput($sformatf("cpu_rdata for %h", addr), cpu_rdata, e.rdata);
      checkOutput($sformatf("cpu_hit for %h", addr), cpu_hit, e.hit);
      if (exp_lat > 0) checkOutput($sformatf("latency for %h", addr), cycles, exp_lat);
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("ready pulse width %h", addr), {cpu_ready, cpu_hit}, 2'b00);
    checkOutput($sformatf("l2 txns outstanding %h", addr), l2_sb.size(), 0);
  endtask

  // L2 responder: waits l2_lat request cycles, then pulses l2_ready and scores the transfer.
  initial begin : l2_model
    bit                   wr;
    logic [31:0]          a;
    logic [BS-1:0][DW-1:0] blk;
    int                   lat;
    int                   held;
    bit                   aborted;
    l2_exp_t              e;
    forever begin
      @(negedge clk);
      l2_ready = 1'b0;
      #1;
      if (rst_n === 1'b1 && (l2_read === 1'b1 || l2_write === 1'b1)) begin
        checkOutput("l2 read/write exclusive", {31'b0, l2_read & l2_write}, 0);
        wr = l2_write;
        a = l2_addr;
        blk = l2_wdata;
        lat = l2_lat;
        held = 1;
        aborted = 0;
        for (int c = 1; c < lat && !aborted; c++) begin
          @(negedge clk);
          #1;
          if (rst_n !== 1'b1) aborted = 1;
          else if ((wr ? l2_write : l2_read) === 1'b1 && l2_addr === a) held++;
        end
        if (!aborted) begin
          checkOutput($sformatf("l2 request held %h", a), held, lat);
          if (wr) begin
            for (int k = 0; k < BS; k++) l2_mem[a + 32'(k)] = blk[k];
          end else begin
            for (int k = 0; k < BS; k++) l2_rdata[k] = l2_word(a + 32'(k));
          end
          l2_ready = 1'b1;
          #1;
          checkOutput($sformatf("l2 request drop %h", a), {30'b0, l2_read, l2_write}, 0);
          checkOutput($sformatf("l2 txn expected %h", a), {31'b0, l2_sb.size() > 0}, 1);
          if (l2_sb.size() > 0) begin
            e = l2_sb.pop_front();
            checkOutput("l2 op is write", {31'b0, wr}, {31'b0, e.wr});
            checkOutput("l2_addr", a, e.addr);
            if (wr) checkOutput("l2_wdata[3]", blk[3], e.w3);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin : main
    int waited;
    rst_n     = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    l2_ready  = 1'b0;
    l2_rdata  = '0;
    @(negedge clk);
    checkOutput("reset cpu_ready", cpu_ready, 0);
    checkOutput("reset cpu_hit", cpu_hit, 0);
    checkOutput("reset cpu_rdata", cpu_rdata, 0);
    checkOutput("reset l2_addr", l2_addr, 0);
    checkOutput("reset l2_wdata zero", {31'b0, l2_wdata === '0}, 1);
    checkOutput("reset l2_read", l2_read, 0);
    checkOutput("reset l2_write", l2_write, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read miss, then a read hit in the same line.
    pushL2(0, 32'h120, 0);
    applyStimulus(1, 0, 32'h123, 0, 1, 32'hA003, 0, 0);
    applyStimulus(1, 0, 32'h125, 0, 1, 32'hA005, 1, 2);

    // Write hit dirties the line; a conflicting read evicts it, then refills.
    applyStimulus(0, 1, 32'h123, 32'hDEADBEEF, 0, 0, 1, 2);
    pushL2(1, 32'h120, 32'hDEADBEEF);
    pushL2(0, 32'h220, 0);
    applyStimulus(1, 0, 32'h223, 0, 1, 32'hA103, 0, 0);

    // Write miss to an invalid line: refill only, then the merged word hits.
    pushL2(0, 32'h300, 0);
    applyStimulus(0, 1, 32'h305, 32'h12345678, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h305, 0, 1, 32'h12345678, 1, 2);

    // Slow L2: request must stay up for all 20 wait cycles.
    l2_lat = 20;
    pushL2(0, 32'h4A0, 0);
    applyStimulus(1, 0, 32'h4A7, 0, 1, 32'hA387, 0, 0);
    l2_lat = 3;

    // Read and write together behave as a write.
    applyStimulus(1, 1, 32'h4A8, 32'hCAFEF00D, 0, 0, 1, 2);
    applyStimulus(1, 0, 32'h4A8, 0, 1, 32'hCAFEF00D, 1, 2);

    // Clean victim is dropped silently; refill sees the earlier writeback.
    pushL2(0, 32'h120, 0);
    applyStimulus(1, 0, 32'h123, 0, 1, 32'hDEADBEEF, 0, 0);

    // Reset in the middle of a writeback of the dirty 0x4A0 line.
    l2_lat = 1000;
    cpu_addr = 32'h5A0;
    cpu_read = 1'b1;
    waited = 0;
    while (l2_write !== 1'b1 && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("writeback started", l2_write, 1);
    checkOutput("writeback l2_addr", l2_addr, 32'h4A0);
    checkOutput("writeback word 3", l2_wdata[3], 32'hA383);
    checkOutput("writeback word 8", l2_wdata[8], 32'hCAFEF00D);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset drops l2_write", l2_write, 0);
    checkOutput("reset l2_read mid-op", l2_read, 0);
    checkOutput("reset l2_addr mid-op", l2_addr, 0);
    checkOutput("reset cpu_ready mid-op", cpu_ready, 0);
    cpu_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    l2_lat = 3;
    rst_n = 1'b1;
    @(negedge clk);

    // Every line is invalid after reset; dirty data at 0x305 was lost.
    pushL2(0, 32'h120, 0);
    applyStimulus(1, 0, 32'h125, 0, 1, 32'hA005, 0, 0);
    pushL2(0, 32'h300, 0);
    applyStimulus(1, 0, 32'h305, 0, 1, 32'hA1E5, 0, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
